// File: rtl/raw2rgb_2x2_pkg.sv
// Shared types for the RAW-to-RGB debayer stage.
//   pix_t     : packed 24-bit RGB pixel {R, G, B}
//   bus11_t   : 11-bit row counter type
//   raw_t     : RAW Bayer sample at the default 8-bit width
//   bayer_e   : colour-filter phase of pixel (0,0)
//   colour_e  : colour of a single CFA site
//   colour_of : colour of a site from its column/row parity and the CFA phase
package raw2rgb_2x2_pkg;

    typedef logic [23:0] pix_t;
    typedef logic [10:0] bus11_t;

    localparam int unsigned RawW = 8;
    typedef logic [RawW-1:0] raw_t;

    localparam bus11_t RowMax = 11'd2047;

    typedef enum logic [1:0] {
        Rggb = 2'd0,
        Bggr = 2'd1,
        Grbg = 2'd2,
        Gbrg = 2'd3
    } bayer_e;

    typedef enum logic [1:0] {
        ColR = 2'd0,
        ColG = 2'd1,
        ColB = 2'd2
    } colour_e;

    // Every CFA phase is RGGB shifted by one column and/or one row.
    function automatic colour_e colour_of(input logic col_odd, input logic row_odd,
                                          input bayer_e bayer);
        logic c;
        logic r;
        c = col_odd ^ ((bayer == Bggr) || (bayer == Grbg));
        r = row_odd ^ ((bayer == Bggr) || (bayer == Gbrg));
        if (!c && !r) begin
            return ColR;
        end else if (c && r) begin
            return ColB;
        end
        return ColG;
    endfunction

endpackage

// File: rtl/raw2rgb_2x2_if.sv
// CSI input stream and RGB output stream of the debayer stage.
//   csi_in_frame / csi_in_line : CSI frame and line strobes
//   raw_valid / raw_pix        : RAW pixel stream
//   rgb_reading / rgb_pix      : RGB pixel strobe and data
//   line_overflow              : sticky "line longer than the line buffer"
// master: the side that sources RAW pixels; slave: the debayer block.
interface raw2rgb_2x2_if #(
    parameter int unsigned PIX_W = 8
);
    import raw2rgb_2x2_pkg::*;

    logic             csi_in_frame;
    logic             csi_in_line;
    logic             raw_valid;
    logic [PIX_W-1:0] raw_pix;
    logic             rgb_reading;
    pix_t             rgb_pix;
    logic             line_overflow;

    modport master (
        output csi_in_frame, csi_in_line, raw_valid, raw_pix,
        input  rgb_reading, rgb_pix, line_overflow
    );

    modport slave (
        input  csi_in_frame, csi_in_line, raw_valid, raw_pix,
        output rgb_reading, rgb_pix, line_overflow
    );

endinterface

// File: rtl/raw2rgb_linebuf.sv
// Single-port read-first line buffer (infers block RAM).
//   clk     : clock
//   en_i    : access enable; reads the old word and writes wdata_i
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data (value before the write)
module raw2rgb_linebuf #(
    parameter int unsigned Depth = 1920,
    parameter int unsigned Width = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // No reset: contents are don't-care until overwritten by row 0.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q        <= mem_q[addr_i];
            mem_q[addr_i]  <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/raw2rgb_2x2.sv
// 2x2 bilinear debayer: one RGB pixel out per RAW pixel in.
//   clk    : pixel clock
//   reset  : synchronous, active-high reset
//   bus_io : CSI RAW input / RGB output stream (slave side)
// Output for column c is formed when pixel c+1 arrives; a repeat of the last
// column is emitted after the line ends so the per-line count stays equal.
module raw2rgb_2x2
    import raw2rgb_2x2_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 1920,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned BAYER      = 0
) (
    input logic          clk,
    input logic          reset,
    raw2rgb_2x2_if.slave bus_io
);

    localparam int unsigned AddrW   = $clog2(LINE_WIDTH);
    localparam int unsigned XW      = $clog2(LINE_WIDTH + 1);
    localparam bayer_e      Pattern = bayer_e'(BAYER[1:0]);

    logic             frame_q, line_q;
    logic [XW-1:0]    x_q, x_d, x_eff;
    bus11_t           y_q, y_d;
    logic             ovf_q, ovf_d;
    logic             line_rise, line_fall, frame_rise;
    logic             acc, in_range, wr_en;

    logic             v1_q, flush1_q;
    logic [XW-1:0]    col1_q;
    bus11_t           row1_q;
    logic [PIX_W-1:0] d1_q, prev_b_q, prev_d_q, ram_rdata;

    logic [PIX_W-1:0] win_val [4];
    logic             win_col [4];
    logic             win_row [4];
    logic [PIX_W-1:0] r_val, b_val, g_avg;
    logic [PIX_W:0]   g_sum;
    logic             out_v;
    pix_t             rgb_q, rgb_d;
    logic             rgb_reading_q, rgb_reading_d;

    assign line_rise  = bus_io.csi_in_line & ~line_q;
    assign line_fall  = ~bus_io.csi_in_line & line_q;
    assign frame_rise = bus_io.csi_in_frame & ~frame_q;
    assign x_eff      = line_rise ? '0 : x_q;
    assign acc        = bus_io.raw_valid & bus_io.csi_in_frame & bus_io.csi_in_line;
    assign in_range   = x_eff < XW'(LINE_WIDTH);
    assign wr_en      = acc & in_range;

    always_comb begin
        x_d = x_eff;
        if (!bus_io.csi_in_frame) begin
            x_d = '0;
        end else if (wr_en) begin
            x_d = x_eff + 1'b1;
        end

        y_d = y_q;
        if (!bus_io.csi_in_frame) begin
            y_d = '0;
        end else if (line_fall && (y_q != RowMax)) begin
            y_d = y_q + 1'b1;
        end

        ovf_d = frame_rise ? 1'b0 : ovf_q;
        if (acc && !in_range) begin
            ovf_d = 1'b1;
        end
    end

    raw2rgb_linebuf #(
        .Depth (LINE_WIDTH),
        .Width (PIX_W)
    ) u_linebuf (
        .clk     (clk),
        .en_i    (wr_en),
        .addr_i  (x_eff[AddrW-1:0]),
        .wdata_i (bus_io.raw_pix),
        .rdata_o (ram_rdata)
    );

    // Window for column c = col1_q - 1: A/B from the previous row, C/D from
    // this row; A/C are the samples held from the previous accepted pixel.
    always_comb begin
        win_val[0] = prev_b_q;  win_col[0] = ~col1_q[0]; win_row[0] = ~row1_q[0];
        win_val[1] = ram_rdata; win_col[1] = col1_q[0];  win_row[1] = ~row1_q[0];
        win_val[2] = prev_d_q;  win_col[2] = ~col1_q[0]; win_row[2] = row1_q[0];
        win_val[3] = d1_q;      win_col[3] = col1_q[0];  win_row[3] = row1_q[0];
        r_val = '0;
        b_val = '0;
        g_sum = '0;
        for (int i = 0; i < 4; i++) begin
            case (colour_of(win_col[i], win_row[i], Pattern))
                ColR:    r_val = win_val[i];
                ColB:    b_val = win_val[i];
                default: g_sum = g_sum + {1'b0, win_val[i]};
            endcase
        end
        g_avg = PIX_W'(g_sum >> 1);
    end

    always_comb begin
        out_v         = v1_q && (col1_q != '0);
        rgb_reading_d = out_v | flush1_q;
        rgb_d         = rgb_q;  // flush repeats the held value
        if (out_v) begin
            if (row1_q == '0) begin
                rgb_d = '0;
            end else begin
                rgb_d = {r_val[PIX_W-1 -: 8], g_avg[PIX_W-1 -: 8], b_val[PIX_W-1 -: 8]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q       <= 1'b0;
            line_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            ovf_q         <= 1'b0;
            v1_q          <= 1'b0;
            flush1_q      <= 1'b0;
            col1_q        <= '0;
            row1_q        <= '0;
            d1_q          <= '0;
            prev_b_q      <= '0;
            prev_d_q      <= '0;
            rgb_q         <= '0;
            rgb_reading_q <= 1'b0;
        end else begin
            frame_q       <= bus_io.csi_in_frame;
            line_q        <= bus_io.csi_in_line;
            x_q           <= x_d;
            y_q           <= y_d;
            ovf_q         <= ovf_d;
            v1_q          <= wr_en;
            // Frame still high on the previous cycle: a frame abort gets no flush.
            flush1_q      <= line_fall & frame_q & (x_q >= XW'(2));
            if (wr_en) begin
                col1_q <= x_eff;
                row1_q <= y_q;
                d1_q   <= bus_io.raw_pix;
            end
            if (v1_q) begin
                prev_b_q <= ram_rdata;
                prev_d_q <= d1_q;
            end
            rgb_q         <= rgb_d;
            rgb_reading_q <= rgb_reading_d;
        end
    end

    assign bus_io.rgb_reading   = rgb_reading_q;
    assign bus_io.rgb_pix       = rgb_q;
    assign bus_io.line_overflow = ovf_q;

endmodule

// File: tb/tb_raw2rgb_2x2.sv
// Directed bench for raw2rgb_2x2 (LINE_WIDTH=8, RGGB) with a scoreboard queue.
module tb_raw2rgb_2x2;

    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    raw2rgb_2x2_if #(.PIX_W(8)) bus_if ();

    raw2rgb_2x2 #(
        .LINE_WIDTH (LW),
        .PIX_W      (8),
        .BAYER      (0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] exp_q [$];
    int          got_cyc [$];
    logic [23:0] got_pix [$];
    logic [7:0]  ld [16];
    logic [7:0]  lb [LW];
    int          my_y;
    int          t_px1, t_fall;
    logic [23:0] last_e;

    // Scoreboard: every strobe pops one expectation.
    always @(negedge clk) begin
        if (bus_if.rgb_reading === 1'b1) begin
            got_cyc.push_back(cyc);
            got_pix.push_back(bus_if.rgb_pix);
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_strobe got=0x%06h required=none", bus_if.rgb_pix);
            end
            if (exp_q.size() != 0) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (bus_if.rgb_pix === e) else begin
                    failures++;
                    $error("FAIL rgb_pix got=0x%06h required=0x%06h", bus_if.rgb_pix, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
        checks++;
        assert (got === req) else begin
            failures++;
            $error("FAIL %s got=0x%0h required=0x%0h", tag, got, req);
        end
    endtask

    // RGGB reference: even row/even col = R, odd/odd = B, else G.
    function automatic logic [23:0] model_pix(input int c, input int y, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] cc,
                                              input logic [7:0] d);
        logic [7:0] v [4];
        int         cols [4];
        int         rows [4];
        logic [7:0] r8;
        logic [7:0] b8;
        int         gs;
        logic [7:0] g8;
        if (y == 0) return 24'h000000;
        v[0] = a;  v[1] = b;  v[2] = cc; v[3] = d;
        cols[0] = c; cols[1] = c + 1; cols[2] = c; cols[3] = c + 1;
        rows[0] = y - 1; rows[1] = y - 1; rows[2] = y; rows[3] = y;
        r8 = 8'h00;
        b8 = 8'h00;
        gs = 0;
        for (int k = 0; k < 4; k++) begin
            if ((rows[k] % 2 == 0) && (cols[k] % 2 == 0)) r8 = v[k];
            else if ((rows[k] % 2 == 1) && (cols[k] % 2 == 1)) b8 = v[k];
            else gs = gs + int'(v[k]);
        end
        g8 = 8'(gs / 2);
        return {r8, g8, b8};
    endfunction

    task automatic set_ld4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d);
        ld[0] = a; ld[1] = b; ld[2] = c; ld[3] = d;
    endtask

    // mode 0: normal line end; 1: frame dropped with line high; 2: reset mid-line.
    task automatic drive_line(input int n, input int mode);
        logic [7:0]  prev_row [LW];
        logic [7:0]  cur_row [LW];
        logic [23:0] e;
        int          acc_n;
        acc_n = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus_if.csi_in_line = 1'b1;
            bus_if.raw_valid   = 1'b1;
            bus_if.raw_pix     = ld[i];
            if (i == 1) t_px1 = cyc;
            if (i < LW) begin
                prev_row[i] = lb[i];
                cur_row[i]  = ld[i];
                lb[i]       = ld[i];
                acc_n++;
                if (i >= 1) begin
                    e = model_pix(i - 1, my_y, prev_row[i-1], prev_row[i], cur_row[i-1],
                                  cur_row[i]);
                    exp_q.push_back(e);
                    last_e = e;
                end
            end
        end
        @(posedge clk); #1;
        bus_if.raw_valid = 1'b0;
        if (mode == 0) begin
            bus_if.csi_in_line = 1'b0;
            t_fall = cyc;
            if (acc_n >= 2) exp_q.push_back(last_e);
            my_y++;
        end else if (mode == 1) begin
            bus_if.csi_in_frame = 1'b0;
            @(posedge clk); #1;
            bus_if.csi_in_line = 1'b0;
            my_y = 0;
        end else begin
            reset = 1'b1;
            bus_if.csi_in_line  = 1'b0;
            bus_if.csi_in_frame = 1'b0;
            my_y = 0;
        end
        if (mode != 2) begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_begin();
        @(posedge clk); #1;
        bus_if.csi_in_frame = 1'b1;
        my_y = 0;
    endtask

    task automatic frame_end();
        @(posedge clk); #1;
        bus_if.csi_in_frame = 1'b0;
        my_y = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic scenario1(input string tag);
        frame_begin();
        set_ld4(8'd10, 8'd20, 8'd12, 8'd22);
        got_cyc.delete(); got_pix.delete();
        drive_line(4, 0);
        chk({tag, "_line0_count"}, got_cyc.size(), 4);
        set_ld4(8'd30, 8'd40, 8'd32, 8'd42);
        got_cyc.delete(); got_pix.delete();
        drive_line(4, 0);
        chk({tag, "_line1_count"}, got_cyc.size(), 4);
        chk({tag, "_px1_latency"}, got_cyc[0], t_px1 + 2);
        chk({tag, "_flush_latency"}, got_cyc[3], t_fall + 2);
        chk({tag, "_col0"}, got_pix[0], 24'h0A1928);
        chk({tag, "_col1"}, got_pix[1], 24'h0C1A28);
        chk({tag, "_col2"}, got_pix[2], 24'h0C1B2A);
        chk({tag, "_flush"}, got_pix[3], 24'h0C1B2A);
        frame_end();
    endtask

    initial begin
        reset = 1'b1;
        bus_if.csi_in_frame = 1'b0;
        bus_if.csi_in_line  = 1'b0;
        bus_if.raw_valid    = 1'b0;
        bus_if.raw_pix      = 8'h00;
        my_y = 0;
        for (int i = 0; i < LW; i++) lb[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_reading", bus_if.rgb_reading, 0);
        chk("reset_pix", bus_if.rgb_pix, 0);
        chk("reset_ovf", bus_if.line_overflow, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        scenario1("s1");

        // Over-long lines: 8 strobes per line, sticky overflow.
        frame_begin();
        for (int i = 0; i < 10; i++) ld[i] = 8'(i * 7 + 5);
        drive_line(10, 0);
        for (int i = 0; i < 10; i++) ld[i] = 8'(200 - i * 13);
        got_cyc.delete();
        drive_line(10, 0);
        chk("ovf_count", got_cyc.size(), 8);
        chk("ovf_set", bus_if.line_overflow, 1);
        frame_end();
        chk("ovf_sticky", bus_if.line_overflow, 1);
        frame_begin();
        @(posedge clk);
        @(negedge clk);
        chk("ovf_cleared", bus_if.line_overflow, 0);

        // Single-pixel line, then a normal line.
        ld[0] = 8'd99;
        got_cyc.delete();
        drive_line(1, 0);
        chk("short_count", got_cyc.size(), 0);
        set_ld4(8'd50, 8'd60, 8'd70, 8'd80);
        got_cyc.delete();
        drive_line(4, 0);
        chk("after_short_count", got_cyc.size(), 4);
        frame_end();

        // Frame abort mid-line.
        frame_begin();
        set_ld4(8'd1, 8'd2, 8'd3, 8'd4);
        drive_line(4, 0);
        set_ld4(8'd100, 8'd110, 8'd120, 8'd130);
        got_cyc.delete();
        drive_line(3, 1);
        chk("abort_count", got_cyc.size(), 2);
        repeat (2) @(posedge clk);
        frame_begin();
        set_ld4(8'd9, 8'd8, 8'd7, 8'd6);
        got_cyc.delete(); got_pix.delete();
        drive_line(4, 0);
        chk("post_abort_count", got_cyc.size(), 4);
        chk("post_abort_black", got_pix[1], 24'h000000);
        frame_end();

        // Reset mid-line.
        frame_begin();
        set_ld4(8'd11, 8'd22, 8'd33, 8'd44);
        drive_line(4, 0);
        set_ld4(8'd30, 8'd40, 8'd32, 8'd42);
        drive_line(3, 2);
        @(posedge clk);
        @(negedge clk);
        chk("midreset_reading", bus_if.rgb_reading, 0);
        chk("midreset_pix", bus_if.rgb_pix, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        scenario1("s6");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
